// File: rtl/median_sched.sv
// Two-requester round-robin scheduler for a shared fixed-latency median unit, with
// per-requester 2-entry response FIFOs. Optional issue counters: MEDIAN_SCHED_ISSUE_COUNT_EN.
module median_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_w0,
    input  logic [WIDTH-1:0] req0_w1,
    input  logic [WIDTH-1:0] req0_w2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_w0,
    input  logic [WIDTH-1:0] req1_w1,
    input  logic [WIDTH-1:0] req1_w2,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             m_rst_n,
    output logic [WIDTH-1:0] m_word0,
    output logic [WIDTH-1:0] m_word1,
    output logic [WIDTH-1:0] m_word2,
    input  logic [WIDTH-1:0] m_median_word,
    output logic             busy,
    output logic [31:0]      issue_cnt0,
    output logic [31:0]      issue_cnt1
);

    typedef enum logic [1:0] {INIT_HI, INIT_LO, INIT_REL, RUN} state_t;

    state_t           state_q, state_d;
    logic             m_rst_n_q, m_rst_n_d;
    logic [LAT-1:0]   tv_q, tv_d;
    logic [LAT-1:0]   tid_q, tid_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       occ_q [2];
    logic [1:0]       occ_d [2];
    logic [1:0]       rd_q, rd_d;
    logic [1:0]       wr_q, wr_d;
    logic [WIDTH-1:0] mem_q [2][2];
    logic [WIDTH-1:0] mem_d [2][2];

    logic       run;
    logic [3:0] infl0, infl1;
    logic       elig0, elig1, cont0, cont1, iss0, iss1, issue;
    logic [1:0] rsp_ready_v;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_HI:  state_d = INIT_LO;
            INIT_LO:  state_d = INIT_REL;
            INIT_REL: state_d = RUN;
            default:  state_d = RUN;
        endcase
        m_rst_n_d = (state_d != INIT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_HI;
            m_rst_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            m_rst_n_q <= m_rst_n_d;
        end
    end

    assign run     = (state_q == RUN);
    assign m_rst_n = m_rst_n_q;
    assign busy    = !run || (|tv_q);

    always_comb begin
        infl0 = '0;
        infl1 = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            if (tv_q[k]) begin
                if (tid_q[k]) infl1 = infl1 + 4'd1;
                else          infl0 = infl0 + 4'd1;
            end
        end
    end

    // Results already in flight count against FIFO space so the FIFO can never overflow.
    assign elig0 = (infl0 + {2'b00, occ_q[0]}) < 4'd2;
    assign elig1 = (infl1 + {2'b00, occ_q[1]}) < 4'd2;
    assign cont0 = req0_valid && elig0;
    assign cont1 = req1_valid && elig1;

    assign req0_ready = run && elig0 && (!cont1 || ptr_q);
    assign req1_ready = run && elig1 && (!cont0 || !ptr_q);
    assign iss0  = req0_valid && req0_ready;
    assign iss1  = req1_valid && req1_ready;
    assign issue = iss0 || iss1;

    always_comb begin
        m_word0 = '0;
        m_word1 = '0;
        m_word2 = '0;
        if (iss0) begin
            m_word0 = req0_w0;
            m_word1 = req0_w1;
            m_word2 = req0_w2;
        end else if (iss1) begin
            m_word0 = req1_w0;
            m_word1 = req1_w1;
            m_word2 = req1_w2;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (iss0)      ptr_d = 1'b0;
        else if (iss1) ptr_d = 1'b1;
        tv_d     = tv_q;
        tid_d    = tid_q;
        tv_d[0]  = issue;
        tid_d[0] = iss1;
        for (int unsigned k = 1; k < LAT; k++) begin
            tv_d[k]  = tv_q[k-1];
            tid_d[k] = tid_q[k-1];
        end
    end

    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    always_comb begin
        logic push;
        logic pop;
        occ_d = occ_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        mem_d = mem_q;
        push  = 1'b0;
        pop   = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            push = tv_q[LAT-1] && (tid_q[LAT-1] == 1'(i));
            pop  = (occ_q[i] != 2'd0) && rsp_ready_v[i];
            if (push) begin
                mem_d[i][wr_q[i]] = m_median_word;
                wr_d[i] = ~wr_q[i];
            end
            if (pop) rd_d[i] = ~rd_q[i];
            occ_d[i] = occ_q[i] + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tv_q   <= '0;
            tid_q  <= '0;
            ptr_q  <= 1'b1;
            occ_q  <= '{2'd0, 2'd0};
            rd_q   <= '0;
            wr_q   <= '0;
        end else begin
            tv_q   <= tv_d;
            tid_q  <= tid_d;
            ptr_q  <= ptr_d;
            occ_q  <= occ_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
        mem_q <= mem_d;
    end

    assign rsp0_valid = (occ_q[0] != 2'd0);
    assign rsp1_valid = (occ_q[1] != 2'd0);
    assign rsp0_data  = rsp0_valid ? mem_q[0][rd_q[0]] : '0;
    assign rsp1_data  = rsp1_valid ? mem_q[1][rd_q[1]] : '0;

`ifdef MEDIAN_SCHED_ISSUE_COUNT_EN
    logic [31:0] issue_cnt0_q, issue_cnt0_d;
    logic [31:0] issue_cnt1_q, issue_cnt1_d;

    always_comb begin
        issue_cnt0_d = issue_cnt0_q + {31'd0, iss0};
        issue_cnt1_d = issue_cnt1_q + {31'd0, iss1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt0_q <= '0;
            issue_cnt1_q <= '0;
        end else begin
            issue_cnt0_q <= issue_cnt0_d;
            issue_cnt1_q <= issue_cnt1_d;
        end
    end

    assign issue_cnt0 = issue_cnt0_q;
    assign issue_cnt1 = issue_cnt1_q;
`else
    assign issue_cnt0 = '0;
    assign issue_cnt1 = '0;
`endif

endmodule

// File: tb/tb_median_sched.sv
// Randomized self-checking bench for median_sched against a transaction-level model
// (per-requester queues of expected medians with arrival times).
module tb_median_sched;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 1;

    logic             clk, rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_w0, req0_w1, req0_w2, req1_w0, req1_w1, req1_w2;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic             m_rst_n, busy;
    logic [WIDTH-1:0] m_word0, m_word1, m_word2, m_median_word;
    logic [31:0]      issue_cnt0, issue_cnt1;

    median_sched #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_w0(req0_w0), .req0_w1(req0_w1), .req0_w2(req0_w2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_w0(req1_w0), .req1_w1(req1_w1), .req1_w2(req1_w2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .m_rst_n(m_rst_n), .m_word0(m_word0), .m_word1(m_word1), .m_word2(m_word2),
        .m_median_word(m_median_word), .busy(busy),
        .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, b, c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    // Behavioural median unit with LAT cycles of latency.
    logic [WIDTH-1:0] mu_pipe [LAT];
    always @(posedge clk) begin
        mu_pipe[0] <= med3(m_word0, m_word1, m_word2);
        for (int k = 1; k < int'(LAT); k++) mu_pipe[k] <= mu_pipe[k-1];
    end
    assign m_median_word = mu_pipe[LAT-1];

    typedef struct { logic [WIDTH-1:0] med; int acc; } item_t;
    item_t q0[$];
    item_t q1[$];
    int    cyc   = 0;
    int    since = 0;
    logic  last  = 1'b1;
    logic [31:0] ecnt0 = '0;
    logic [31:0] ecnt1 = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            since = 1;
            q0.delete();
            q1.delete();
            last  = 1'b1;
            ecnt0 = '0;
            ecnt1 = '0;
        end else if (since > 0 && since < 1000) begin
            since++;
        end
    end

    function automatic bit in_pipe(input item_t q[$], input int now);
        foreach (q[j]) if (q[j].acc < now && now <= q[j].acc + int'(LAT)) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        bit run, e0, e1, c0, c1, r0, r1, a0, a1, v0, v1;
        logic [WIDTH-1:0] x0, x1, x2;
        item_t it;
        if (since >= 1) begin
            run = (since >= 4);
            e0  = q0.size() < 2;
            e1  = q1.size() < 2;
            c0  = req0_valid && e0;
            c1  = req1_valid && e1;
            r0  = run && e0 && (!c1 || last == 1'b1);
            r1  = run && e1 && (!c0 || last == 1'b0);
            a0  = req0_valid && r0;
            a1  = req1_valid && r1;
            check_val("req0_ready", req0_ready, r0);
            check_val("req1_ready", req1_ready, r1);
            check_val("m_rst_n", m_rst_n, since != 2);
            check_val("busy", busy, !run || in_pipe(q0, cyc) || in_pipe(q1, cyc));
            x0 = a0 ? req0_w0 : a1 ? req1_w0 : '0;
            x1 = a0 ? req0_w1 : a1 ? req1_w1 : '0;
            x2 = a0 ? req0_w2 : a1 ? req1_w2 : '0;
            check_val("m_word0", m_word0, x0);
            check_val("m_word1", m_word1, x1);
            check_val("m_word2", m_word2, x2);
            v0 = q0.size() > 0 && q0[0].acc + int'(LAT) + 1 <= cyc;
            v1 = q1.size() > 0 && q1[0].acc + int'(LAT) + 1 <= cyc;
            check_val("rsp0_valid", rsp0_valid, v0);
            check_val("rsp1_valid", rsp1_valid, v1);
            if (v0) check_val("rsp0_data", rsp0_data, q0[0].med);
            if (v1) check_val("rsp1_data", rsp1_data, q1[0].med);
            if (since == 1) begin
                check_val("rsp0_data_rst", rsp0_data, 0);
                check_val("rsp1_data_rst", rsp1_data, 0);
            end
`ifdef MEDIAN_SCHED_ISSUE_COUNT_EN
            check_val("issue_cnt0", issue_cnt0, ecnt0);
            check_val("issue_cnt1", issue_cnt1, ecnt1);
`else
            check_val("issue_cnt0", issue_cnt0, 0);
            check_val("issue_cnt1", issue_cnt1, 0);
`endif
            if (!rst) begin
                if (v0 && rsp0_ready) void'(q0.pop_front());
                if (v1 && rsp1_ready) void'(q1.pop_front());
                if (a0) begin
                    it.med = med3(req0_w0, req0_w1, req0_w2);
                    it.acc = cyc;
                    q0.push_back(it);
                    last  = 1'b0;
                    ecnt0 = ecnt0 + 32'd1;
                end
                if (a1) begin
                    it.med = med3(req1_w0, req1_w1, req1_w2);
                    it.acc = cyc;
                    q1.push_back(it);
                    last  = 1'b1;
                    ecnt1 = ecnt1 + 32'd1;
                end
            end
        end
    end

    task automatic set_idle();
        req0_valid = 0; req1_valid = 0;
        req0_w0 = '0; req0_w1 = '0; req0_w2 = '0;
        req1_w0 = '0; req1_w1 = '0; req1_w2 = '0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
    endfunction

    task automatic rand_req(input int p0, input int p1);
        req0_valid = ($urandom_range(0, 99) < p0);
        req1_valid = ($urandom_range(0, 99) < p1);
        req0_w0 = rnd_word(); req0_w1 = rnd_word(); req0_w2 = rnd_word();
        req1_w0 = rnd_word(); req1_w1 = rnd_word(); req1_w2 = rnd_word();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            set_idle();
        end
    endtask

    initial begin
        int n0;
        rst = 1; rsp0_ready = 1; rsp1_ready = 1;
        set_idle();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle_cycles(8);

        // Single directed triple from requester 0.
        @(posedge clk); #1;
        req0_valid = 1; req0_w0 = 5; req0_w1 = 9; req0_w2 = 7;
        @(negedge clk);
        check_val("dir_accept", req0_ready, 1);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        check_val("dir_rsp0_valid", rsp0_valid, 1);
        check_val("dir_rsp0_data", rsp0_data, 7);
        check_val("dir_rsp1_valid", rsp1_valid, 0);
        idle_cycles(4);

        // Both requesters saturating.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            rand_req(100, 100);
        end
        idle_cycles(6);

        // Requester 0 backpressured on its response side.
        rsp0_ready = 0;
        n0 = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rand_req(100, 100);
            @(negedge clk);
            if (req0_valid && req0_ready) n0++;
        end
        check_val("hold_acc0", n0, 2);
        rsp0_ready = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rand_req(100, 100);
            @(negedge clk);
            if (req0_valid && req0_ready) n0++;
        end
        check_val("resume_acc0", n0 > 2, 1);
        idle_cycles(6);

        // Fully random traffic and response backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rand_req(60, 60);
            rsp0_ready = ($urandom_range(0, 99) < 60);
            rsp1_ready = ($urandom_range(0, 99) < 60);
        end
        rsp0_ready = 1; rsp1_ready = 1;
        idle_cycles(6);

        // Reset with results in flight: none may surface afterwards.
        rsp0_ready = 0; rsp1_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rand_req(100, 100);
        end
        @(posedge clk); #1;
        set_idle();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        idle_cycles(10);

`ifdef MEDIAN_SCHED_ISSUE_COUNT_EN
        @(posedge clk); #2;
        force dut.issue_cnt0_q = 32'hFFFF_FFFF;
        ecnt0 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.issue_cnt0_q;
        req0_valid = 1; req0_w0 = 1; req0_w1 = 2; req0_w2 = 3;
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check_val("cnt0_wrap", issue_cnt0, 0);
        idle_cycles(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/median_sched.md
MEDIAN_SCHED -- requirements
Module: median_sched

Interface
REQ-001 Parameter WIDTH, default 32: data word width of all request, response and median-unit words.
REQ-002 Parameter LAT, default 1: fixed median-unit latency in cycles, from word inputs to median_word; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester i offers a triple.
REQ-006 req0_ready, req1_ready  output  1 each  triple accepted this cycle when valid and ready are both high.
REQ-007 req0_w0/w1/w2, req1_w0/w1/w2  input  WIDTH each  operand triple for requester i.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  median result available to requester i.
REQ-009 rsp0_ready, rsp1_ready  input  1 each  requester i consumes the result.
REQ-010 rsp0_data, rsp1_data  output  WIDTH each  median result for requester i.
REQ-011 m_rst_n  output  1  active-low reset to the shared median unit.
REQ-012 m_word0, m_word1, m_word2  output  WIDTH each  operands to the median unit.
REQ-013 m_median_word  input  WIDTH  median-unit result, valid LAT cycles after issue.
REQ-014 busy  output  1  high while not in RUN or while any result is in flight.
REQ-015 issue_cnt0, issue_cnt1  output  32 each  per-requester issued-triple counters (see Configuration).

Function
REQ-016 FSM states INIT_HI -> INIT_LO -> INIT_REL -> RUN, one cycle each; m_rst_n is 1, 0, 1 in the three INIT states and 1 in RUN; RUN is held until rst.
REQ-017 Both req_ready SHALL be 0 outside RUN.
REQ-018 At most one triple issues per cycle; issue drives m_word0/1/2 from the winner's w0/w1/w2 in the same cycle (combinational); m_word* SHALL be 0 on cycles with no issue.
REQ-019 Arbitration is round-robin: a last-grant pointer (reset 1, so requester 0 wins first) flips to the winner on every issue; when only one eligible requester is valid, it wins.
REQ-020 Requester i is eligible only if inflight_i + occ_i < 2, where inflight_i is the count of i-tagged entries in the LAT-deep tag pipeline and occ_i is the occupancy of i's 2-entry response FIFO; ready_i = RUN && eligible_i && (won arbitration).
REQ-021 A valid/tag shift register of depth LAT carries {valid, requester id}; on its output cycle m_median_word is written into that requester's response FIFO.
REQ-022 Response FIFO i: 2 entries, FIFO order; rsp_valid_i = occ_i != 0; rsp_data_i = head entry; pop on rsp_valid && rsp_ready; simultaneous push and pop keep occ unchanged; overflow is impossible by REQ-020.
REQ-023 Results per requester SHALL be delivered in issue order; end-to-end latency is LAT+1 cycles from the accept edge to rsp_valid when the FIFO is empty.
REQ-024 busy = (state != RUN) || any tag-pipeline valid bit set.

Reset
REQ-025 On rst: state INIT_HI, tag pipeline cleared, both FIFOs emptied, pointer = 1, counters 0; outputs: req_ready 0, rsp_valid 0, rsp_data 0, m_rst_n 1, m_word* 0, busy 1.
REQ-026 rst asserted mid-operation discards in-flight and buffered results; no rsp_valid is produced for them after rst deasserts.

Configuration
REQ-027 Macro MEDIAN_SCHED_ISSUE_COUNT_EN: when defined, issue_cnt_i increments by 1 on each issue for requester i and wraps from 2^32-1 to 0; when undefined, issue_cnt0/1 are tied to 0 and no counter flops exist.

Verification
REQ-028 Reset, then idle: m_rst_n sequence 1,0,1 over cycles 1-3; req_ready first high in cycle 4; busy falls in cycle 4.
REQ-029 LAT=1, req0 only with (5,9,7), rsp0_ready=1 -> rsp0_data=7 exactly 2 cycles after accept; rsp1_valid stays 0.
REQ-030 Both requesters valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; each requester receives its results in order.
REQ-031 rsp0_ready=0, req0 streaming -> exactly 2 accepts then req0_ready=0 while req1 continues to issue; raising rsp0_ready resumes req0.
REQ-032 rst pulsed with 2 triples in flight -> no rsp_valid after reset; INIT sequence repeats.
REQ-033 With MEDIAN_SCHED_ISSUE_COUNT_EN, issue_cnt0 preloaded via force to 32'hFFFFFFFF, one issue -> 0; without the macro, counters read 0 throughout.
